// File: rtl/fnd_display_ctrl.sv
// -----------------------------------------------------------------------------
// fnd_display_ctrl
// Shows an 8-bit unsigned value in decimal on a 4-digit common-anode
// 7-segment display. A new value is converted to three BCD digits by an
// iterative double-dabble engine (8 shift cycles). A prescaled scan counter
// multiplexes the digits and blanks leading zeros.
//
// Ports
//   clk       system clock, all state on the rising edge
//   reset     asynchronous, active-high reset
//   value_in  [7:0] unsigned binary value to display
//   seg       [7:0] segment drive, active-low, {dp,g,f,e,d,c,b,a}
//   an        [3:0] digit enables, active-low, an[0] = ones digit
//   busy      high while a conversion is in progress
// -----------------------------------------------------------------------------
module fnd_display_ctrl #(
    parameter int SCAN_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] value_in,
    output logic [7:0] seg,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    // Layout of the working register: {hundreds, tens, ones, binary[7:0]}.
    function automatic logic [19:0] dd_step(input logic [19:0] v);
        logic [19:0] t;
        t = v;
        for (int i = 8; i < 20; i += 4) begin
            if (t[i +: 4] >= 4'd5) begin
                t[i +: 4] = t[i +: 4] + 4'd3;
            end else begin
                t[i +: 4] = t[i +: 4];
            end
        end
        return {t[18:0], 1'b0};
    endfunction

    // Active-low segment pattern for one decimal digit, dp off.
    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] s;
        case (d)
            4'd0:    s = 8'hC0;
            4'd1:    s = 8'hF9;
            4'd2:    s = 8'hA4;
            4'd3:    s = 8'hB0;
            4'd4:    s = 8'h99;
            4'd5:    s = 8'h92;
            4'd6:    s = 8'h82;
            4'd7:    s = 8'hF8;
            4'd8:    s = 8'h80;
            4'd9:    s = 8'h90;
            default: s = 8'hFF;
        endcase
        return s;
    endfunction

    state_t        r_state;
    state_t        w_next_state;
    logic          w_busy_next;
    logic [7:0]    r_sample;
    logic [7:0]    r_shown;
    logic [7:0]    r_conv_val;
    logic [19:0]   r_shift;
    logic [2:0]    r_bit_cnt;
    logic [3:0]    r_d_hun;
    logic [3:0]    r_d_ten;
    logic [3:0]    r_d_one;
    logic [PW-1:0] r_presc;
    logic [1:0]    r_digit_sel;
    logic [7:0]    r_seg;
    logic [3:0]    r_an;
    logic          r_busy;
    logic [7:0]    w_seg_next;
    logic [3:0]    w_an_next;

    assign seg  = r_seg;
    assign an   = r_an;
    assign busy = r_busy;

    // Converter state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Converter next-state and busy decode.
    always_comb begin
        w_next_state = r_state;
        w_busy_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_sample != r_shown) begin
                    w_next_state = ST_SHIFT;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                w_busy_next = 1'b1;
                // bit_cnt == 7 marks the eighth and final shift.
                if (r_bit_cnt == 3'd7) begin
                    w_next_state = ST_LOAD;
                end else begin
                    w_next_state = ST_SHIFT;
                end
            end
            ST_LOAD: begin
                w_busy_next  = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Input capture and conversion datapath.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sample   <= 8'd0;
            r_shown    <= 8'd0;
            r_conv_val <= 8'd0;
            r_shift    <= 20'd0;
            r_bit_cnt  <= 3'd0;
            r_d_hun    <= 4'd0;
            r_d_ten    <= 4'd0;
            r_d_one    <= 4'd0;
        end else begin
            r_sample <= value_in;
            case (r_state)
                ST_IDLE: begin
                    if (r_sample != r_shown) begin
                        r_shift    <= {12'd0, r_sample};
                        r_conv_val <= r_sample;
                        r_bit_cnt  <= 3'd0;
                    end else begin
                        r_bit_cnt  <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    r_shift   <= dd_step(r_shift);
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                ST_LOAD: begin
                    r_d_hun <= r_shift[19:16];
                    r_d_ten <= r_shift[15:12];
                    r_d_one <= r_shift[11:8];
                    // Only the value actually converted is marked as shown, so a
                    // change that arrived mid-conversion is picked up in IDLE.
                    r_shown <= r_conv_val;
                end
                default: begin
                    r_bit_cnt <= 3'd0;
                end
            endcase
        end
    end

    // Scan prescaler and digit slot selector.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc     <= '0;
            r_digit_sel <= 2'd0;
        end else begin
            if (r_presc == PRESC_LAST) begin
                r_presc     <= '0;
                r_digit_sel <= r_digit_sel + 2'd1;
            end else begin
                r_presc     <= r_presc + PW'(1);
            end
        end
    end

    // Slot content with leading-zero blanking.
    always_comb begin
        w_seg_next = 8'hFF;
        w_an_next  = 4'b1111;
        case (r_digit_sel)
            2'd0: begin
                w_an_next  = 4'b1110;
                w_seg_next = seg_code(r_d_one);
            end
            2'd1: begin
                w_an_next = 4'b1101;
                if ((r_d_hun == 4'd0) && (r_d_ten == 4'd0)) begin
                    w_seg_next = 8'hFF;
                end else begin
                    w_seg_next = seg_code(r_d_ten);
                end
            end
            2'd2: begin
                w_an_next = 4'b1011;
                if (r_d_hun == 4'd0) begin
                    w_seg_next = 8'hFF;
                end else begin
                    w_seg_next = seg_code(r_d_hun);
                end
            end
            2'd3: begin
                w_an_next  = 4'b0111;
                w_seg_next = 8'hFF;
            end
            default: begin
                w_an_next  = 4'b1111;
                w_seg_next = 8'hFF;
            end
        endcase
    end

    // Registered outputs; seg and an load together so they never disagree.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg  <= 8'hFF;
            r_an   <= 4'b1111;
            r_busy <= 1'b0;
        end else begin
            r_seg  <= w_seg_next;
            r_an   <= w_an_next;
            r_busy <= w_busy_next;
        end
    end

endmodule

// File: tb/tb_fnd_display_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fnd_display_ctrl
// Self-checking bench for fnd_display_ctrl with SCAN_DIV = 4. Expected slot
// codes come from a decimal reference model (/, %) and are queued when a value
// is applied, then compared against the scanned seg/an output.
// -----------------------------------------------------------------------------
module tb_fnd_display_ctrl;

    logic       clk;
    logic       reset;
    logic [7:0] value_in;
    logic [7:0] seg;
    logic [3:0] an;
    logic       busy;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];
    logic [31:0] cur_codes;

    fnd_display_ctrl #(.SCAN_DIV(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .value_in (value_in),
        .seg      (seg),
        .an       (an),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference segment table.
    function automatic logic [7:0] ref_code(input int d);
        logic [7:0] t[10];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return t[d];
    endfunction

    // Expected slot codes {slot3, slot2, slot1, slot0} for a value.
    function automatic logic [31:0] exp_codes(input int v);
        int h, t, o;
        logic [7:0] s0, s1, s2;
        h  = v / 100;
        t  = (v / 10) % 10;
        o  = v % 10;
        s0 = ref_code(o);
        s1 = (h == 0 && t == 0) ? 8'hFF : ref_code(t);
        s2 = (h == 0) ? 8'hFF : ref_code(h);
        return {8'hFF, s2, s1, s0};
    endfunction

    function automatic int slot_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Busy window E+2..E+10 and seg switch between E+10 and E+11.
    // Called just after capture edge E.
    task automatic check_latency(input string name, input logic [31:0] old_c,
                                 input logic [31:0] new_c);
        logic exp_b;
        logic [7:0] exp_s;
        int s;
        for (int k = 1; k <= 11; k++) begin
            step();
            exp_b = (k >= 2 && k <= 10);
            n_vec++;
            if (busy !== exp_b) begin
                n_err++;
                $display("FAIL %s busy@E+%0d: got %b expected %b", name, k, busy, exp_b);
            end
            if (k >= 10) begin
                s = slot_of(an);
                n_vec++;
                if (s < 0) begin
                    n_err++;
                    $display("FAIL %s an@E+%0d: got %b expected one-hot low", name, k, an);
                end else begin
                    exp_s = (k == 10) ? old_c[s*8 +: 8] : new_c[s*8 +: 8];
                    if (seg !== exp_s) begin
                        n_err++;
                        $display("FAIL %s seg@E+%0d slot%0d: got %h expected %h",
                                 name, k, s, seg, exp_s);
                    end
                end
            end
        end
    endtask

    // Pop expected codes and compare over one full 16-cycle scan.
    task automatic check_display(input string name);
        logic [31:0] e;
        int s;
        bit found;
        e = exp_q.pop_front();
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (an === 4'b1110) found = 1'b1;
            else step();
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL %s scan_start: got an=%b expected 1110 within 20 cycles", name, an);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (k > 0) step();
                s = slot_of(an);
                n_vec++;
                if (s < 0) begin
                    n_err++;
                    $display("FAIL %s an: got %b expected one-hot low", name, an);
                end else if (seg !== e[s*8 +: 8]) begin
                    n_err++;
                    $display("FAIL %s seg slot%0d: got %h expected %h", name, s, seg, e[s*8 +: 8]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        value_in = 8'd0;
        repeat (3) step();
        n_vec++;
        if (seg !== 8'hFF || an !== 4'b1111 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold: got seg=%h an=%b busy=%b expected FF 1111 0", seg, an, busy);
        end
        reset = 1'b0;
        step();
        n_vec++;
        if (seg !== 8'hC0 || an !== 4'b1110 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got seg=%h an=%b busy=%b expected C0 1110 0", seg, an, busy);
        end
        repeat (5) step();
        // Asynchronous assertion mid-cycle must clear outputs without an edge.
        #2;
        reset = 1'b1;
        #1;
        n_vec++;
        if (seg !== 8'hFF || an !== 4'b1111) begin
            n_err++;
            $display("FAIL reset_async: got seg=%h an=%b expected FF 1111", seg, an);
        end
        step();
        reset = 1'b0;
        step();
        n_vec++;
        if (seg !== 8'hC0 || an !== 4'b1110 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async_release: got seg=%h an=%b busy=%b expected C0 1110 0",
                     seg, an, busy);
        end
        cur_codes = exp_codes(0);
    endtask

    // Each slot held exactly 4 cycles in order 1110,1101,1011,0111.
    task automatic test_scan();
        logic [3:0] pat[4];
        logic [3:0] prev;
        bit found;
        pat = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        found = 1'b0;
        prev = an;
        for (int i = 0; i < 20 && !found; i++) begin
            prev = an;
            step();
            if (an === 4'b1110 && prev !== 4'b1110) found = 1'b1;
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $display("FAIL scan_sync: got an=%b expected transition into 1110", an);
        end else begin
            for (int k = 0; k < 16; k++) begin
                if (k > 0) step();
                n_vec++;
                if (an !== pat[k/4] || seg !== cur_codes[(k/4)*8 +: 8]) begin
                    n_err++;
                    $display("FAIL scan k=%0d: got an=%b seg=%h expected an=%b seg=%h",
                             k, an, seg, pat[k/4], cur_codes[(k/4)*8 +: 8]);
                end
            end
            step();
            n_vec++;
            if (an !== 4'b1110) begin
                n_err++;
                $display("FAIL scan_wrap: got an=%b expected 1110", an);
            end
        end
    endtask

    task automatic test_value(input int v);
        logic [31:0] c;
        string nm;
        nm = $sformatf("value_%0d", v);
        c = exp_codes(v);
        value_in = v[7:0];
        step();
        exp_q.push_back(c);
        check_latency(nm, cur_codes, c);
        cur_codes = c;
        check_display(nm);
    endtask

    // 10 at E, 200 captured at E+4. First LOAD at E+10 (10 shown at E+11),
    // second conversion detected at E+11, shifts E+12..E+19, LOAD E+20,
    // 200 on seg at E+21.
    task automatic test_back_to_back();
        logic [31:0] c10, c200, e;
        logic exp_b;
        int s;
        c10 = exp_codes(10);
        c200 = exp_codes(200);
        value_in = 8'd10;
        step();
        exp_q.push_back(c200);
        for (int k = 1; k <= 21; k++) begin
            step();
            exp_b = (k >= 2 && k <= 10) || (k >= 12 && k <= 20);
            n_vec++;
            if (busy !== exp_b) begin
                n_err++;
                $display("FAIL b2b busy@E+%0d: got %b expected %b", k, busy, exp_b);
            end
            if (k == 10 || k == 11 || k == 20 || k == 21) begin
                e = (k == 10) ? cur_codes : ((k == 21) ? c200 : c10);
                s = slot_of(an);
                n_vec++;
                if (s < 0 || seg !== e[((s < 0) ? 0 : s)*8 +: 8]) begin
                    n_err++;
                    $display("FAIL b2b seg@E+%0d: got seg=%h an=%b expected slot code from %h",
                             k, seg, an, e);
                end
            end
            if (k == 3) value_in = 8'd200;
        end
        cur_codes = c200;
        check_display("b2b_200");
    endtask

    task automatic test_reset_during_shift();
        logic [31:0] c99;
        c99 = exp_codes(99);
        value_in = 8'd99;
        step();
        repeat (5) step();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL rst_shift_busy: got %b expected 1", busy);
        end
        reset = 1'b1;
        #1;
        n_vec++;
        if (busy !== 1'b0 || seg !== 8'hFF || an !== 4'b1111) begin
            n_err++;
            $display("FAIL rst_shift_abort: got busy=%b seg=%h an=%b expected 0 FF 1111",
                     busy, seg, an);
        end
        step();
        reset = 1'b0;
        step();
        n_vec++;
        if (seg !== 8'hC0 || an !== 4'b1110 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_shift_zero: got seg=%h an=%b busy=%b expected C0 1110 0",
                     seg, an, busy);
        end
        // First edge after release captured 99; conversion proceeds from here.
        exp_q.push_back(c99);
        check_latency("rst_shift_99", exp_codes(0), c99);
        cur_codes = c99;
        check_display("rst_shift_99");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        value_in = 8'd0;
        test_reset();
        test_scan();
        test_value(55);
        test_value(255);
        test_value(7);
        test_value(100);
        test_back_to_back();
        test_reset_during_shift();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
